cyc_24_pucch1_spread: RTL and testbench

Sequencer for the NR PUCCH format 1 orthogonal cover code w_i(m) (TS 38.211 Table 6.3.2.4.1-2). It outputs the phase of each OCC element as an integer count of 1/24 cycle. Phases are produced one per request, feeding the PUCCH format 1 time-domain spreading/phase-rotation stage. Only N_SF values whose phases are exact multiples of 1/24 cycle are supported: 1, 2, 3, 4 and 6.

---
 rtl/cyc_24_pucch1_pkg.sv | 24 ++
 rtl/cyc_24_pucch1_phase.sv | 34 +++
 rtl/cyc_24_pucch1_spread.sv | 83 ++++++++
 tb/tb_cyc_24_pucch1_spread.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cyc_24_pucch1_pkg.sv
// Purpose : shared widths, phase step constants and N_SF support check for the
//           PUCCH format 1 OCC phase sequencer.
// Latency : n/a (package). Backpressure: n/a.
package cyc_24_pucch1_pkg;

  localparam int NSF_W = 3;
  localparam int PHI_W = 5;

  // Phase step per unit of the reduced index, in 1/24 cycle.
  localparam logic [PHI_W-1:0] STEP_NSF24 = 5'd12;  // N_SF 2/4: +-1 -> 0 or 1/2 cycle
  localparam logic [PHI_W-1:0] STEP_NSF3  = 5'd8;   // N_SF 3: 1/3 cycle
  localparam logic [PHI_W-1:0] STEP_NSF6  = 5'd4;   // N_SF 6: 1/6 cycle

  // Only spreading factors whose OCC phases land on the 1/24 grid.
  function automatic logic support(input logic [NSF_W-1:0] nsf);
    logic ok;
    case (nsf)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd6: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cyc_24_pucch1_phase.sv
// Purpose : combinational OCC element phase phi(nSF, occi, m) in 1/24 cycle.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports   : nsf/occi/m in, phi out (0..20). Unsupported N_SF gives 0.
module cyc_24_pucch1_phase
  import cyc_24_pucch1_pkg::*;
(
  input  logic [NSF_W-1:0] nsf,
  input  logic [2:0]       occi,
  input  logic [2:0]       m,
  output logic [PHI_W-1:0] phi
);

  logic [5:0] q;
  logic [5:0] r3;
  logic [5:0] r6;
  logic       par;

  always_comb begin
    q   = {3'b000, occi} * {3'b000, m};
    r3  = q % 6'd3;
    r6  = q % 6'd6;
    // Walsh codes of length 2 and 4 are the parity of i AND m.
    par = ^(occi & m);
    phi = '0;
    case (nsf)
      3'd2, 3'd4: phi = par ? STEP_NSF24 : '0;
      3'd3:       phi = r3[PHI_W-1:0] * STEP_NSF3;
      3'd6:       phi = r6[PHI_W-1:0] * STEP_NSF6;
      default:    phi = '0;
    endcase
  end

endmodule

// File: rtl/cyc_24_pucch1_spread.sv
// Purpose : sequences PUCCH format 1 OCC phases w_i(m), one per i_next request.
// Latency : 1 cycle from accepted i_next to o_valid; one element per cycle max.
// Backpressure: none; i_next outside an active sequence is dropped.
// Ports   : clk, rst (async active-low), i_start/i_next/i_nSF/i_occi in;
//           o_wi_phi, o_done, o_valid, o_is_supported out (all registered).
// Config  : PUCCH1_SPREAD_OCCI_CHECK_EN -- when defined, i_occi >= i_nSF is
//           flagged unsupported and produces zero phases.
module cyc_24_pucch1_spread
  import cyc_24_pucch1_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_next,
  input  logic [NSF_W-1:0] i_nSF,
  input  logic [2:0]       i_occi,
  output logic [PHI_W-1:0] o_wi_phi,
  output logic             o_done,
  output logic             o_valid,
  output logic             o_is_supported
);

  logic [NSF_W-1:0] nSF;
  logic [2:0]       occi;
  logic [2:0]       m;
  logic             active;

  logic [NSF_W-1:0] len;
  logic             last;
  logic             sup_next;
  logic [PHI_W-1:0] phi;

  cyc_24_pucch1_phase u_phase (
    .nsf  (nSF),
    .occi (occi),
    .m    (m),
    .phi  (phi)
  );

  // N_SF = 0 still steps a single element so the sequence always terminates.
  assign len  = (nSF == '0) ? 3'd1 : nSF;
  assign last = (m == 3'(len - 3'd1));

`ifdef PUCCH1_SPREAD_OCCI_CHECK_EN
  assign sup_next = support(i_nSF) && (i_occi < i_nSF);
`else
  assign sup_next = support(i_nSF);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nSF            <= '0;
      occi           <= '0;
      m              <= '0;
      active         <= 1'b0;
      o_wi_phi       <= '0;
      o_valid        <= 1'b0;
      o_done         <= 1'b0;
      o_is_supported <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      if (i_start) begin
        // Start wins over a concurrent i_next and discards any running sequence.
        nSF            <= i_nSF;
        occi           <= i_occi;
        m              <= '0;
        active         <= 1'b1;
        o_is_supported <= sup_next;
      end else if (i_next && active) begin
        o_valid  <= 1'b1;
        // Gating on the latched support flag also zeroes out-of-range occi.
        o_wi_phi <= o_is_supported ? phi : '0;
        m        <= m + 3'd1;
        if (last) begin
          o_done <= 1'b1;
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cyc_24_pucch1_spread.sv
module tb_cyc_24_pucch1_spread;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic       i_next;
  logic [2:0] i_nSF;
  logic [2:0] i_occi;
  logic [4:0] o_wi_phi;
  logic       o_done;
  logic       o_valid;
  logic       o_is_supported;

  int n_chk;
  int n_fail;
  int exp_q[7];

  cyc_24_pucch1_spread dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_next         (i_next),
    .i_nSF          (i_nSF),
    .i_occi         (i_occi),
    .o_wi_phi       (o_wi_phi),
    .o_done         (o_done),
    .o_valid        (o_valid),
    .o_is_supported (o_is_supported)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference phase: Walsh tables for 2/4 (bit set = -1), 24*i*m/N for 3/6.
  function automatic int model_phi(input int nsf, input int occi, input int m);
    logic [1:0] w2 [2];
    logic [3:0] w4 [4];
    int r;
    w2 = '{2'b00, 2'b10};
    w4 = '{4'b0000, 4'b1010, 4'b1100, 4'b0110};
    r = 0;
    case (nsf)
      2:       r = w2[occi][m] ? 12 : 0;
      4:       r = w4[occi][m] ? 12 : 0;
      3, 6:    r = ((24 * occi * m) / nsf) % 24;
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic int model_sup(input int nsf);
    return (nsf == 1 || nsf == 2 || nsf == 3 || nsf == 4 || nsf == 6) ? 1 : 0;
  endfunction

  // Start a sequence, step len elements checking against exp_q, then one
  // extra i_next while idle which must be dropped.
  task automatic run_seq(input int nsf, input int occi, input int sup, input int len);
    string id;
    id = $sformatf("n%0d_i%0d", nsf, occi);
    i_start = 1'b1;
    i_nSF   = 3'(nsf);
    i_occi  = 3'(occi);
    cyc();
    i_start = 1'b0;
    chk({id, "_start_vld"}, int'(o_valid), 0);
    chk({id, "_start_sup"}, int'(o_is_supported), sup);
    for (int k = 0; k < len; k++) begin
      i_next = 1'b1;
      cyc();
      chk($sformatf("%s_m%0d_vld", id, k), int'(o_valid), 1);
      chk($sformatf("%s_m%0d_phi", id, k), int'(o_wi_phi), exp_q[k]);
      chk($sformatf("%s_m%0d_done", id, k), int'(o_done), (k == len - 1) ? 1 : 0);
      chk($sformatf("%s_m%0d_sup", id, k), int'(o_is_supported), sup);
    end
    cyc();
    chk({id, "_idle_vld"}, int'(o_valid), 0);
    chk({id, "_idle_done"}, int'(o_done), 0);
    chk({id, "_hold_phi"}, int'(o_wi_phi), exp_q[len-1]);
    i_next = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b0;
    i_start = 1'b0;
    i_next  = 1'b0;
    i_nSF   = '0;
    i_occi  = '0;
    cyc();
    cyc();
    chk("rst_phi", int'(o_wi_phi), 0);
    chk("rst_vld", int'(o_valid), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_sup", int'(o_is_supported), 0);
    rst = 1'b1;
    cyc();

    // Idle i_next after reset: no sequence active.
    i_next = 1'b1;
    cyc();
    chk("idle_vld", int'(o_valid), 0);
    i_next = 1'b0;

    // Directed vectors.
    exp_q = '{0, 12, 12, 0, 0, 0, 0};
    run_seq(4, 3, 1, 4);
    exp_q = '{0, 12, 0, 0, 0, 0, 0};
    run_seq(2, 1, 1, 2);
    exp_q = '{0, 20, 16, 12, 8, 4, 0};
    run_seq(6, 5, 1, 6);
    exp_q = '{0, 16, 8, 0, 0, 0, 0};
    run_seq(3, 2, 1, 3);
    exp_q = '{0, 0, 0, 0, 0, 0, 0};
    run_seq(5, 4, 0, 5);
    run_seq(7, 6, 0, 7);
    run_seq(0, 0, 0, 1);
    run_seq(1, 0, 1, 1);

    // occi beyond N_SF: wraps without the check, zero and unsupported with it.
`ifdef PUCCH1_SPREAD_OCCI_CHECK_EN
    exp_q = '{0, 0, 0, 0, 0, 0, 0};
    run_seq(3, 4, 0, 3);
`else
    exp_q = '{0, 8, 16, 0, 0, 0, 0};
    run_seq(3, 4, 1, 3);
`endif

    // Sweep nSF 1..7 x occi 0..nSF-1 against the reference model.
    for (int n = 1; n <= 7; n++) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 7; k++)
          exp_q[k] = (k < n) ? model_phi(n, i, k) : 0;
        run_seq(n, i, model_sup(n), n);
      end
    end

    // Restart mid-sequence: two elements of 6/5, then 4/3 with a colliding i_next.
    i_start = 1'b1; i_nSF = 3'd6; i_occi = 3'd5;
    cyc();
    i_start = 1'b0; i_next = 1'b1;
    cyc();
    cyc();
    chk("rs_pre_phi", int'(o_wi_phi), 20);
    i_start = 1'b1; i_nSF = 3'd4; i_occi = 3'd3;
    cyc();
    i_start = 1'b0;
    chk("rs_start_vld", int'(o_valid), 0);
    exp_q = '{0, 12, 12, 0, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("rs_m%0d_vld", k), int'(o_valid), 1);
      chk($sformatf("rs_m%0d_phi", k), int'(o_wi_phi), exp_q[k]);
      chk($sformatf("rs_m%0d_done", k), int'(o_done), (k == 3) ? 1 : 0);
    end
    i_next = 1'b0;
    cyc();

    // Asynchronous reset during an active sequence.
    i_start = 1'b1; i_nSF = 3'd6; i_occi = 3'd5;
    cyc();
    i_start = 1'b0; i_next = 1'b1;
    cyc();
    cyc();
    i_next = 1'b0;
    chk("ar_pre_phi", int'(o_wi_phi), 20);
    #2 rst = 1'b0;
    #1;
    chk("ar_phi", int'(o_wi_phi), 0);
    chk("ar_sup", int'(o_is_supported), 0);
    chk("ar_vld", int'(o_valid), 0);
    cyc();
    rst = 1'b1;
    i_next = 1'b1;
    cyc();
    chk("ar_next_vld", int'(o_valid), 0);
    chk("ar_next_done", int'(o_done), 0);
    i_next = 1'b0;
    exp_q = '{0, 12, 0, 0, 0, 0, 0};
    run_seq(2, 1, 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
